// File: rtl/cc_level_rowloader_pkg.sv
// Shared widths, level geometry and FSM state encoding for the level row loader.
package cc_level_rowloader_pkg;

  localparam int unsigned CC_DATAWIDTH      = 8;
  localparam int unsigned CC_LEVEL_DW       = 3;
  localparam int unsigned CC_PROGRESS_DW    = 5;
  localparam int unsigned CC_ROWS           = 8;
  localparam int unsigned CC_LAST_PROGRESS  = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/cc_level_rowshifter.sv
// Playfield shift register: newest row enters at the top, oldest row falls off the bottom.
module cc_level_rowshifter #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic [DATAWIDTH-1:0]      row_i,
  output logic [ROWS*DATAWIDTH-1:0] matrix_o
);

  logic [ROWS*DATAWIDTH-1:0] matrix_q, matrix_d;

  // Clear wins over push so a restart always begins from an empty field.
  always_comb begin
    matrix_d = matrix_q;
    if (clr_i) begin
      matrix_d = '0;
    end else if (push_i) begin
      matrix_d = {row_i, matrix_q[ROWS*DATAWIDTH-1:DATAWIDTH]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      matrix_q <= '0;
    end else begin
      matrix_q <= matrix_d;
    end
  end

  assign matrix_o = matrix_q;

endmodule

// File: rtl/cc_level_rowloader.sv
// Level row loader: preloads a screen of rows, then fetches one row per scroll tick.
// Optional endless scroll when CC_LEVEL_ROWLOADER_WRAP_EN is defined.
module cc_level_rowloader
  import cc_level_rowloader_pkg::*;
#(
  parameter int unsigned DATAWIDTH               = CC_DATAWIDTH,
  parameter int unsigned CURRENTLEVEL_DATAWIDTH  = CC_LEVEL_DW,
  parameter int unsigned LEVELPROGRESS_DATAWIDTH = CC_PROGRESS_DW,
  parameter int unsigned ROWS                    = CC_ROWS,
  parameter int unsigned LAST_PROGRESS           = CC_LAST_PROGRESS
) (
  input  logic                               CC_LEVEL_ROWLOADER_CLOCK_50,
  input  logic                               CC_LEVEL_ROWLOADER_RESET_InLow,
  input  logic                               CC_LEVEL_ROWLOADER_Start_In,
  input  logic [CURRENTLEVEL_DATAWIDTH-1:0]  CC_LEVEL_ROWLOADER_Level_InBus,
  input  logic                               CC_LEVEL_ROWLOADER_Tick_In,
  input  logic [DATAWIDTH-1:0]               CC_LEVEL_ROWLOADER_LevelData_InBus,
  output logic [LEVELPROGRESS_DATAWIDTH-1:0] CC_LEVEL_ROWLOADER_LvlProgress_OutBus,
  output logic [CURRENTLEVEL_DATAWIDTH-1:0]  CC_LEVEL_ROWLOADER_CurrentLvl_OutBus,
  output logic [ROWS*DATAWIDTH-1:0]          CC_LEVEL_ROWLOADER_Matrix_OutBus,
  output logic                               CC_LEVEL_ROWLOADER_Busy_Out,
  output logic                               CC_LEVEL_ROWLOADER_Done_Out
);

  localparam logic [LEVELPROGRESS_DATAWIDTH-1:0] PROG_ROWS = LEVELPROGRESS_DATAWIDTH'(ROWS);
  localparam logic [LEVELPROGRESS_DATAWIDTH-1:0] PROG_LAST = LEVELPROGRESS_DATAWIDTH'(LAST_PROGRESS);

  state_e                              state_q, state_d;
  logic [LEVELPROGRESS_DATAWIDTH-1:0]  prog_q, prog_d;
  logic [CURRENTLEVEL_DATAWIDTH-1:0]   lvl_q, lvl_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                clr, push;
`ifdef CC_LEVEL_ROWLOADER_WRAP_EN
  logic                                pend_q, pend_d;
`endif

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    lvl_d   = lvl_q;
    clr     = 1'b0;
    push    = 1'b0;
    done_d  = 1'b0;
`ifdef CC_LEVEL_ROWLOADER_WRAP_EN
    pend_d  = 1'b0;
    done_d  = pend_q;
`endif
    case (state_q)
      ST_IDLE: ;
      ST_PRELOAD: begin
        push   = 1'b1;
        prog_d = prog_q + 1'b1;
        if (prog_q == PROG_ROWS) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (CC_LEVEL_ROWLOADER_Tick_In) begin
          push = 1'b1;
          if (prog_q == PROG_LAST) begin
`ifdef CC_LEVEL_ROWLOADER_WRAP_EN
            prog_d = LEVELPROGRESS_DATAWIDTH'(1);
            pend_d = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end else begin
            prog_d = prog_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        prog_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Start overrides whatever the current state decided, but a pending done pulse survives.
    if (CC_LEVEL_ROWLOADER_Start_In) begin
      state_d = ST_PRELOAD;
      lvl_d   = CC_LEVEL_ROWLOADER_Level_InBus;
      prog_d  = LEVELPROGRESS_DATAWIDTH'(1);
      clr     = 1'b1;
      push    = 1'b0;
    end
    busy_d = (state_d == ST_PRELOAD) || (state_d == ST_RUN);
  end

  always_ff @(posedge CC_LEVEL_ROWLOADER_CLOCK_50) begin
    if (!CC_LEVEL_ROWLOADER_RESET_InLow) begin
      state_q <= ST_IDLE;
      prog_q  <= '0;
      lvl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CC_LEVEL_ROWLOADER_WRAP_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      lvl_q   <= lvl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CC_LEVEL_ROWLOADER_WRAP_EN
      pend_q  <= pend_d;
`endif
    end
  end

  cc_level_rowshifter #(
    .ROWS      (ROWS),
    .DATAWIDTH (DATAWIDTH)
  ) u_shifter (
    .clk_i    (CC_LEVEL_ROWLOADER_CLOCK_50),
    .rst_n_i  (CC_LEVEL_ROWLOADER_RESET_InLow),
    .clr_i    (clr),
    .push_i   (push),
    .row_i    (CC_LEVEL_ROWLOADER_LevelData_InBus),
    .matrix_o (CC_LEVEL_ROWLOADER_Matrix_OutBus)
  );

  assign CC_LEVEL_ROWLOADER_LvlProgress_OutBus = prog_q;
  assign CC_LEVEL_ROWLOADER_CurrentLvl_OutBus  = lvl_q;
  assign CC_LEVEL_ROWLOADER_Busy_Out           = busy_q;
  assign CC_LEVEL_ROWLOADER_Done_Out           = done_q;

endmodule

// File: tb/tb_cc_level_rowloader.sv
// Bench for cc_level_rowloader: directed scenarios plus random traffic against a row-queue model.
// Honours CC_LEVEL_ROWLOADER_WRAP_EN the same way the design does.
module tb_cc_level_rowloader;

  logic       clk = 1'b0;
  logic       rst_n, start, tick;
  logic [2:0] level;
  logic [7:0] lvl_data;
  logic [4:0] prog;
  logic [2:0] cur_lvl;
  logic [63:0] mat;
  logic       busy, done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  cc_level_rowloader dut (
    .CC_LEVEL_ROWLOADER_CLOCK_50           (clk),
    .CC_LEVEL_ROWLOADER_RESET_InLow        (rst_n),
    .CC_LEVEL_ROWLOADER_Start_In           (start),
    .CC_LEVEL_ROWLOADER_Level_InBus        (level),
    .CC_LEVEL_ROWLOADER_Tick_In            (tick),
    .CC_LEVEL_ROWLOADER_LevelData_InBus    (lvl_data),
    .CC_LEVEL_ROWLOADER_LvlProgress_OutBus (prog),
    .CC_LEVEL_ROWLOADER_CurrentLvl_OutBus  (cur_lvl),
    .CC_LEVEL_ROWLOADER_Matrix_OutBus      (mat),
    .CC_LEVEL_ROWLOADER_Busy_Out           (busy),
    .CC_LEVEL_ROWLOADER_Done_Out           (done)
  );

  // Level lookup: only level 1 has content, progress 1..12.
  function automatic logic [7:0] lookup(input logic [2:0] lv, input logic [4:0] p);
    logic [7:0] tbl [1:12];
    tbl = '{8'h00, 8'h90, 8'h40, 8'hC0, 8'hD0, 8'h50, 8'h30, 8'hA0, 8'h70, 8'h90, 8'hB0, 8'h50};
    if (lv == 3'd1 && p >= 5'd1 && p <= 5'd12) return tbl[p];
    return 8'h00;
  endfunction

  assign lvl_data = lookup(cur_lvl, prog);

  // Reference model: rows queue (front = newest), progress index and scheduling counters.
  logic [7:0] m_rows[$];
  int         m_prog, m_lvl, m_preload_left;
  bit         m_busy, m_done, m_running, m_pend;

  function automatic logic [63:0] m_matrix();
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) m[63-8*i -: 8] = m_rows[i];
    return m;
  endfunction

  task automatic m_clear_rows();
    m_rows.delete();
    for (int i = 0; i < 8; i++) m_rows.push_back(8'h00);
  endtask

  task automatic m_push(input logic [7:0] r);
    m_rows.push_front(r);
    void'(m_rows.pop_back());
  endtask

  task automatic m_edge(input bit r_n, input bit st, input bit tk, input int lv);
    bit fire;
    logic [7:0] row;
    if (!r_n) begin
      m_clear_rows();
      m_prog = 0; m_lvl = 0; m_busy = 0; m_done = 0;
      m_preload_left = 0; m_running = 0; m_pend = 0;
      return;
    end
    fire   = m_pend;
    m_pend = 0;
    row    = lookup(3'(m_lvl), 5'(m_prog));
    if (st) begin
      m_lvl = lv; m_prog = 1; m_clear_rows();
      m_preload_left = 8; m_running = 1; m_busy = 1;
    end else if (m_preload_left > 0) begin
      m_push(row); m_prog++; m_preload_left--;
    end else if (m_running && tk) begin
      m_push(row);
      if (m_prog == 12) begin
        m_pend = 1;
`ifdef CC_LEVEL_ROWLOADER_WRAP_EN
        m_prog = 1;
`else
        m_running = 0; m_busy = 0;
`endif
      end else begin
        m_prog++;
      end
    end
`ifndef CC_LEVEL_ROWLOADER_WRAP_EN
    else if (fire) m_prog = 0;
`endif
    m_done = fire;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r_n, input bit st, input bit tk, input int lv);
    rst_n = r_n; start = st; tick = tk; level = 3'(lv);
    @(posedge clk);
    m_edge(r_n, st, tk, lv);
    #1;
    check_val("matrix",   mat,     m_matrix());
    check_val("progress", 64'(prog), 64'(m_prog));
    check_val("level",    64'(cur_lvl), 64'(m_lvl));
    check_val("busy",     64'(busy), 64'(m_busy));
    check_val("done",     64'(done), 64'(m_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    m_clear_rows();
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; level = '0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) step(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
    check_val("rst_matrix", mat, 64'h0);
    check_val("rst_busy", 64'(busy), 64'h0);

    // Level 1 start and preload
    step(1, 1, 0, 1);
    check_val("start_busy", 64'(busy), 64'h1);
    idle(8);
    check_val("preload_matrix", mat, 64'hA03050D0C0409000);
    check_val("preload_prog", 64'(prog), 64'd9);

    // Four ticks, 5 cycles apart
    for (int t = 0; t < 4; t++) begin
      step(1, 0, 1, 0);
      if (t < 3) idle(4);
    end
    check_val("run_matrix", mat, 64'h50B09070A03050D0);
    step(1, 0, 0, 0);
    check_val("done_pulse", 64'(done), 64'h1);
`ifdef CC_LEVEL_ROWLOADER_WRAP_EN
    check_val("wrap_busy", 64'(busy), 64'h1);
    check_val("wrap_prog", 64'(prog), 64'd1);
    idle(3);
    step(1, 0, 1, 0);
    check_val("wrap_push_row", 64'(mat[63:56]), 64'h00);
    check_val("wrap_busy2", 64'(busy), 64'h1);
    check_val("wrap_prog2", 64'(prog), 64'd2);
`else
    check_val("done_busy", 64'(busy), 64'h0);
    check_val("done_prog", 64'(prog), 64'd0);
`endif
    step(1, 0, 0, 0);
    check_val("done_once", 64'(done), 64'h0);

    // Ticks during preload, then Start+Tick together mid-RUN
    step(1, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0);
    check_val("tickpre_matrix", mat, 64'hA03050D0C0409000);
    step(1, 0, 1, 0);
    step(1, 1, 1, 1);
    check_val("restart_prog", 64'(prog), 64'd1);
    idle(8);
    check_val("restart_matrix", mat, 64'hA03050D0C0409000);

    // Reset mid-RUN at progress 10
    step(1, 0, 1, 0);
    check_val("mid_prog", 64'(prog), 64'd10);
    step(0, 0, 0, 0);
    check_val("midrst_matrix", mat, 64'h0);
    check_val("midrst_prog", 64'(prog), 64'd0);
    step(1, 1, 0, 1);
    idle(8);
    check_val("fresh_matrix", mat, 64'hA03050D0C0409000);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 149) != 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
